// File: rtl/mux_41_rr_scheduler.sv
// Round-robin scheduler that time-shares a 4:1 mux between four requesters,
// holding each grant until release or until the hold limit expires.
module mux_41_rr_scheduler #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] in,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       valid,
  output logic       out,
  output logic       dbg_state
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_grant;
  logic [1:0]       r_select;
  logic             r_valid;

  state_t           w_state_n;
  logic [1:0]       w_last_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [3:0]       w_grant_n;
  logic [1:0]       w_select_n;
  logic             w_valid_n;
  logic [1:0]       w_base;
  logic [1:0]       w_winner;
  logic             w_release;

  // First requester after base, wrapping; base itself is searched last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd0;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

  // While granted, the holder becomes the new "last" at release time.
  assign w_base    = (r_state == S_GRANT) ? r_select : r_last;
  assign w_winner  = rr_pick(req, w_base);
  assign w_release = !req[r_select] || (r_cnt == HOLD_LAST);

  always_comb begin
    w_state_n  = r_state;
    w_last_n   = r_last;
    w_cnt_n    = r_cnt;
    w_grant_n  = r_grant;
    w_select_n = r_select;
    w_valid_n  = r_valid;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_n  = S_GRANT;
          w_grant_n  = 4'b0001 << w_winner;
          w_select_n = w_winner;
          w_valid_n  = 1'b1;
          w_cnt_n    = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_last_n = r_select;
          w_cnt_n  = '0;
          if (|req) begin
            w_grant_n  = 4'b0001 << w_winner;
            w_select_n = w_winner;
          end else begin
            w_state_n = S_IDLE;
            w_grant_n = 4'b0000;
            w_valid_n = 1'b0;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_grant_n = 4'b0000;
        w_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= 2'd3;
      r_cnt    <= '0;
      r_grant  <= 4'b0000;
      r_select <= 2'd0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_last   <= w_last_n;
      r_cnt    <= w_cnt_n;
      r_grant  <= w_grant_n;
      r_select <= w_select_n;
      r_valid  <= w_valid_n;
    end
  end

  assign grant     = r_grant;
  assign select    = r_select;
  assign valid     = r_valid;
  assign out       = r_valid ? in[r_select] : 1'b0;
  assign dbg_state = r_state;

endmodule

// File: doc/mux_41_rr_scheduler.md
Name: mux_41_rr_scheduler

Overview:
Round-robin scheduler that shares the 4:1 multiplexer datapath between four requesters. It arbitrates 4 request lines and drives the mux select. It holds each grant until the requester releases it or a hold limit expires. The selected data bit is forwarded as the shared output, qualified by a valid flag. It sits in front of the 4:1 mux channel and replaces the static select stimulus with a sequenced, fair one.

Parameters:
MAX_HOLD, 4, max consecutive cycles one requester may hold the grant (legal range 1..2**CNT_W).
CNT_W, 3, width of the hold counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester; bit i = requester i
in  input  4  data; bit i belongs to requester i
grant  output  4  one-hot grant, registered; all-zero when idle
select  output  2  mux select, registered; equals index of the granted bit
valid  output  1  registered; 1 while any grant is held
out  output  1  combinational: in[select] when valid=1, else 0

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately, including mid-grant):
  - grant=0000, select=00, valid=0, out=0.
  - State IDLE, hold_cnt=0.
  - last=3, so requester 0 has first priority after reset.
- Round-robin pick: search order is last+1, last+2, last+3, last (mod 4). The first index with req=1 wins. A requester that just released has lowest priority.
- IDLE:
  - At a posedge with req!=0: go to GRANT; grant=one-hot(winner), select=winner, valid=1, hold_cnt=0.
  - Latency from request to grant is 1 cycle.
  - At a posedge with req=0: stay in IDLE; outputs unchanged.
- GRANT, evaluated at each posedge with g=select:
  - Release when req[g]=0 or hold_cnt==MAX_HOLD-1. On release, last=g.
  - On release with req (sampled at the same edge) !=0 after excluding nothing: re-arbitrate in the same edge using the new last. The new grant is visible next cycle with no idle gap (back-to-back). hold_cnt=0.
  - A sole requester still asserting re-wins immediately: grant is unchanged, hold_cnt=0.
  - On release with req=0: go to IDLE; grant=0000, valid=0. select keeps its last value; out=0.
  - Otherwise (no release): hold_cnt+1; grant and select are unchanged.
- Consequences:
  - A steady requester holds the grant for exactly MAX_HOLD cycles.
  - A requester that drops req at edge k loses its grant after edge k, so the grant is seen for one cycle after the drop is sampled.
- Requests arriving mid-grant never pre-empt; they wait for release.
- Simultaneous release and new requests are resolved in one edge as above.
- grant is always 0000 or one-hot. select always equals log2(grant) while valid=1.
- out is purely combinational from registered select/valid and live in. A change on in propagates within the same cycle.
- No X on any output after reset. req and in are assumed synchronous to clk.

Test Plan:
1. Reset: rst_n=0 with req=1111 -> grant=0000, select=00, valid=0, out=0. Release rst_n, then 1 edge -> grant=0001, select=00, valid=1.
2. Steady contention: MAX_HOLD=4, req=0011, in=1001 -> grant=0001 for 4 cycles (out=1), then 0010 for 4 cycles (out=0), alternating with no idle cycle.
3. Early release: requester 2 granted, req[2] drops at edge k with req=0100->0000 -> grant=0000, valid=0 after edge k. req=1000 two cycles later -> grant=1000, select=11, out=in[3] one edge later.
4. Fairness ordering: last=1 and req=1111 steady -> grant sequence 0100, 1000, 0001, 0010, each held for MAX_HOLD cycles.
5. Sole requester: req=0001 held for 10 cycles, MAX_HOLD=4 -> grant stays 0001 continuously and valid stays 1, with hold_cnt wrapping at 3. Toggling in[0] toggles out in the same cycle.
6. Reset mid-grant: rst_n pulsed low between edges while grant=0100 -> outputs go to reset values immediately without waiting for clk. After release with req=0100, the first grant is 0100.
